// File: rtl/edge2en_multi.sv
// Multi-channel synchroniser, optional glitch filter, edge detector and sticky event flags.
// Define EDGE2EN_MULTI_FILTER_EN to build the per-channel glitch filter.
`timescale 1ns/1ps
module edge2en_multi #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [2*WIDTH-1:0]   mode_i,
  input  logic [WIDTH-1:0]     clr_i,
  output logic [WIDTH-1:0]     level_o,
  output logic [WIDTH-1:0]     pos_edge_o,
  output logic [WIDTH-1:0]     neg_edge_o,
  output logic [WIDTH-1:0]     any_edge_o,
  output logic [WIDTH-1:0]     event_o,
  output logic                 irq_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pos_q, neg_q;
  logic [WIDTH-1:0] event_q, event_d;
  logic [WIDTH-1:0] rise_en, fall_en;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= data_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef EDGE2EN_MULTI_FILTER_EN
  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic [CntW-1:0] cnt_q [WIDTH];
  logic [CntW-1:0] cnt_d [WIDTH];

  // Level follows s only after FILTER_LEN consecutive cycles of disagreement.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
          level_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  logic unused_filter_len;
  assign unused_filter_len = ^FILTER_LEN;

  always_comb begin
    level_d = s;
  end
`endif

  always_comb begin
    rise_en = '0;
    fall_en = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rise_en[i] = mode_i[2*i];
      fall_en[i] = mode_i[2*i+1];
    end
    // A new set condition overrides a same-cycle clear.
    event_d = (event_q & ~clr_i) | (pos_q & rise_en) | (neg_q & fall_en);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      level_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      event_q <= '0;
    end else begin
      level_q <= level_d;
      pos_q   <= level_d & ~level_q;
      neg_q   <= ~level_d & level_q;
      event_q <= event_d;
    end
  end

  assign level_o    = level_q;
  assign pos_edge_o = pos_q;
  assign neg_edge_o = neg_q;
  assign any_edge_o = pos_q | neg_q;
  assign event_o    = event_q;
  assign irq_o      = |event_q;

endmodule

// File: tb/tb_edge2en_multi.sv
// Self-checking bench for edge2en_multi: directed scenarios plus randomized traffic
// compared against a window-based behavioural model.
`timescale 1ns/1ps
module tb_edge2en_multi;
  localparam int W = 4;
  localparam int S = 2;
  localparam int F = 4;
`ifdef EDGE2EN_MULTI_FILTER_EN
  localparam int FL = F;
`else
  localparam int FL = 1;
`endif
  localparam int LAT = S + FL;

  logic           clk_i = 1'b0;
  logic           rst_n_i = 1'b0;
  logic [W-1:0]   data_i = '0;
  logic [2*W-1:0] mode_i = '0;
  logic [W-1:0]   clr_i = '0;
  logic [W-1:0]   level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o;
  logic           irq_o;

  int checks = 0;
  int errors = 0;

  edge2en_multi #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .data_i     (data_i),
    .mode_i     (mode_i),
    .clr_i      (clr_i),
    .level_o    (level_o),
    .pos_edge_o (pos_edge_o),
    .neg_edge_o (neg_edge_o),
    .any_edge_o (any_edge_o),
    .event_o    (event_o),
    .irq_o      (irq_o)
  );

  always #2.5 clk_i = ~clk_i;

  // Reference model: delay line of S samples; level flips once the last FL synchronised
  // samples all disagree with it.
  logic [W-1:0] m_dl [S];
  logic [W-1:0] m_hist [FL];
  logic [W-1:0] m_level, m_pos, m_neg, m_ev, m_rise, m_fall, m_nl;
  bit           m_flip;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) begin
        for (int j = 0; j < S; j++) m_dl[j] = '0;
        for (int j = 0; j < FL; j++) m_hist[j] = '0;
        m_level = '0; m_pos = '0; m_neg = '0; m_ev = '0;
      end else begin
        for (int i = 0; i < W; i++) begin
          m_rise[i] = mode_i[2*i];
          m_fall[i] = mode_i[2*i+1];
        end
        m_ev = (m_ev & ~clr_i) | (m_pos & m_rise) | (m_neg & m_fall);
        for (int j = FL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = m_dl[S-1];
        m_nl = m_level;
        for (int i = 0; i < W; i++) begin
          m_flip = 1'b1;
          for (int j = 0; j < FL; j++) if (m_hist[j][i] == m_level[i]) m_flip = 1'b0;
          if (m_flip) m_nl[i] = ~m_level[i];
        end
        m_pos = m_nl & ~m_level;
        m_neg = ~m_nl & m_level;
        m_level = m_nl;
        for (int j = S - 1; j > 0; j--) m_dl[j] = m_dl[j-1];
        m_dl[0] = data_i;
      end
    end
  end

  task automatic test_reset();
    #1;
    checks++;
    if ({level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o, irq_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got lvl=%b pos=%b neg=%b any=%b ev=%b irq=%b want all 0",
               level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o, irq_o);
    end
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({level_o, pos_edge_o, neg_edge_o, event_o, irq_o} !== '0) begin
      errors++;
      $display("FAIL reset_release: got lvl=%b pos=%b neg=%b ev=%b irq=%b want all 0",
               level_o, pos_edge_o, neg_edge_o, event_o, irq_o);
    end
  endtask

  task automatic test_rise_latency();
    logic [W-1:0] exp_lvl, exp_pos;
    @(negedge clk_i);
    data_i[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_i);
      exp_lvl = (k >= LAT) ? W'(1) : W'(0);
      exp_pos = (k == LAT) ? W'(1) : W'(0);
      checks++;
      if (level_o !== exp_lvl) begin
        errors++;
        $display("FAIL rise_level edge%0d: got %b want %b", k, level_o, exp_lvl);
      end
      checks++;
      if (pos_edge_o !== exp_pos || any_edge_o !== exp_pos || neg_edge_o !== '0) begin
        errors++;
        $display("FAIL rise_pulse edge%0d: got pos=%b any=%b neg=%b want pos=any=%b neg=0",
                 k, pos_edge_o, any_edge_o, neg_edge_o, exp_pos);
      end
    end
    data_i[0] = 1'b0;
    repeat (LAT + 2) @(negedge clk_i);
    checks++;
    if (level_o !== '0) begin
      errors++;
      $display("FAIL rise_fall_back: got %b want 0000", level_o);
    end
  endtask

  task automatic test_glitch();
    mode_i[3:2] = 2'b11;
    @(negedge clk_i);
    data_i[1] = 1'b1;
`ifdef EDGE2EN_MULTI_FILTER_EN
    repeat (2) @(negedge clk_i);
    data_i[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      checks++;
      if ({level_o[1], pos_edge_o[1], neg_edge_o[1], any_edge_o[1], event_o[1]} !== 5'b0) begin
        errors++;
        $display("FAIL glitch_suppress cyc%0d: got lvl=%b pos=%b neg=%b ev=%b want 0",
                 k, level_o[1], pos_edge_o[1], neg_edge_o[1], event_o[1]);
      end
    end
`else
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_i);
      checks++;
      if (pos_edge_o[1] !== (k == 3) || neg_edge_o[1] !== (k == 4)) begin
        errors++;
        $display("FAIL short_pulse edge%0d: got pos=%b neg=%b want pos=%b neg=%b",
                 k, pos_edge_o[1], neg_edge_o[1], (k == 3), (k == 4));
      end
      if (k == 1) data_i[1] = 1'b0;
    end
`endif
    clr_i = '1;
    @(negedge clk_i);
    clr_i = '0;
  endtask

  task automatic test_event_mode();
    mode_i[5:4] = 2'b10;
    @(negedge clk_i);
    data_i[2] = 1'b1;
    for (int k = 1; k <= LAT + 10; k++) begin
      @(negedge clk_i);
      if (k == LAT) begin
        checks++;
        if (pos_edge_o[2] !== 1'b1) begin
          errors++;
          $display("FAIL ev_pos_pulse: got %b want 1", pos_edge_o[2]);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (event_o[2] !== 1'b0 || irq_o !== 1'b0) begin
          errors++;
          $display("FAIL ev_rise_ignored: got ev=%b irq=%b want 0 0", event_o[2], irq_o);
        end
      end
      if (k == LAT + 8) begin
        checks++;
        if (neg_edge_o[2] !== 1'b1) begin
          errors++;
          $display("FAIL ev_neg_pulse: got %b want 1", neg_edge_o[2]);
        end
      end
      if (k == LAT + 9) begin
        checks++;
        if (event_o !== 4'b0100 || irq_o !== 1'b1) begin
          errors++;
          $display("FAIL ev_fall_set: got ev=%b irq=%b want 0100 1", event_o, irq_o);
        end
        clr_i[2] = 1'b1;
      end
      if (k == LAT + 10) begin
        checks++;
        if (event_o[2] !== 1'b0 || irq_o !== 1'b0) begin
          errors++;
          $display("FAIL ev_clear: got ev=%b irq=%b want 0 0", event_o[2], irq_o);
        end
        clr_i[2] = 1'b0;
      end
      if (k == 8) data_i[2] = 1'b0;
    end
  endtask

  task automatic test_clr_collision();
    mode_i[7:6] = 2'b11;
    @(negedge clk_i);
    data_i[3] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk_i);
      if (k == LAT) begin
        checks++;
        if (pos_edge_o[3] !== 1'b1) begin
          errors++;
          $display("FAIL coll_pulse: got %b want 1", pos_edge_o[3]);
        end
        clr_i[3] = 1'b1;
      end
      if (k == LAT + 1) begin
        checks++;
        if (event_o[3] !== 1'b1) begin
          errors++;
          $display("FAIL coll_set_wins: got %b want 1", event_o[3]);
        end
        clr_i[3] = 1'b0;
      end
      if (k == LAT + 2) begin
        checks++;
        if (event_o[3] !== 1'b1 || irq_o !== 1'b1) begin
          errors++;
          $display("FAIL coll_sticky: got ev=%b irq=%b want 1 1", event_o[3], irq_o);
        end
      end
    end
    data_i[3] = 1'b0;
    repeat (LAT + 2) @(negedge clk_i);
  endtask

  task automatic test_reset_mid_filter();
    data_i[1] = 1'b1;
    repeat (LAT + 2) @(negedge clk_i);
    checks++;
    if (level_o[1] !== 1'b1 || event_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got lvl=%b ev=%b want 1 1", level_o[1], event_o[1]);
    end
    data_i[0] = 1'b1;
    repeat (4) @(negedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o, irq_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got lvl=%b pos=%b neg=%b any=%b ev=%b irq=%b want all 0",
               level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o, irq_o);
    end
    data_i = '0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      checks++;
      if (pos_edge_o !== '0 || level_o !== '0) begin
        errors++;
        $display("FAIL rstmid_no_pulse cyc%0d: got pos=%b lvl=%b want 0", k, pos_edge_o, level_o);
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    data_i = W'($urandom);
    mode_i = (2*W)'($urandom);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk_i);
      checks++;
      if (level_o !== m_level || pos_edge_o !== m_pos || neg_edge_o !== m_neg) begin
        errors++;
        $display("FAIL rand_edges cyc%0d: got lvl=%b pos=%b neg=%b want lvl=%b pos=%b neg=%b",
                 k, level_o, pos_edge_o, neg_edge_o, m_level, m_pos, m_neg);
      end
      checks++;
      if (any_edge_o !== (m_pos | m_neg) || event_o !== m_ev || irq_o !== (|m_ev)) begin
        errors++;
        $display("FAIL rand_events cyc%0d: got any=%b ev=%b irq=%b want any=%b ev=%b irq=%b",
                 k, any_edge_o, event_o, irq_o, m_pos | m_neg, m_ev, |m_ev);
      end
      data_i = data_i ^ W'($urandom & $urandom);
      clr_i = W'($urandom & $urandom & $urandom);
      if (k % 50 == 49) mode_i = (2*W)'($urandom);
    end
    clr_i = '0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_event_mode();
    test_clr_collision();
    test_reset_mid_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge2en_multi.md
EDGE2EN_MULTI -- requirements
Module: edge2en_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel (>=2).
REQ-003 SHALL have parameter FILTER_LEN, default 4: consecutive stable cycles required to accept a level change (>=1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port data_i  input  WIDTH  asynchronous channel inputs.
REQ-007 SHALL have port mode_i  input  2*WIDTH  per-channel event mode, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both.
REQ-008 SHALL have port clr_i  input  WIDTH  per-channel sticky-event clear, active-high, synchronous.
REQ-009 SHALL have port level_o  output  WIDTH  filtered channel level.
REQ-010 SHALL have port pos_edge_o  output  WIDTH  one-cycle pulse on filtered 0->1.
REQ-011 SHALL have port neg_edge_o  output  WIDTH  one-cycle pulse on filtered 1->0.
REQ-012 SHALL have port any_edge_o  output  WIDTH  pos_edge_o | neg_edge_o.
REQ-013 SHALL have port event_o  output  WIDTH  sticky event flags.
REQ-014 SHALL have port irq_o  output  1  OR-reduction of event_o.

Function
REQ-015 Each data_i bit SHALL pass through a SYNC_STAGES-flop chain; the last stage is the synchronised value s[i].
REQ-016 With filtering, each channel SHALL keep a counter of $clog2(FILTER_LEN+1) bits: cleared when s[i]==level_o[i]; incremented when they differ; when it would reach FILTER_LEN, level_o[i] <= s[i] and counter <= 0.
REQ-017 A difference on s[i] lasting fewer than FILTER_LEN cycles SHALL leave level_o, the edge outputs and event_o unchanged.
REQ-018 pos_edge_o/neg_edge_o SHALL be registered, asserted exactly in the cycle level_o first shows the new value, and deasserted the following cycle.
REQ-019 Latency data_i change -> level_o/edge pulse SHALL be SYNC_STAGES+FILTER_LEN rising edges with filter, SYNC_STAGES+1 without.
REQ-020 event_o[i] SHALL set at the rising edge after an edge pulse matching mode_i for channel i; mode 00 never sets it; edge outputs are independent of mode_i.
REQ-021 clr_i[i] SHALL clear event_o[i] at the next rising edge; a simultaneous set condition SHALL win (flag remains 1).
REQ-022 mode_i changes SHALL apply to the next edge pulse only; already-set flags are not affected.
REQ-023 irq_o SHALL be combinational from event_o registers only (no path from data_i, mode_i or clr_i).
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be reported in the same cycle.

Reset
REQ-025 rst_n_i low SHALL immediately clear sync chains, counters, level_o, pos_edge_o, neg_edge_o, any_edge_o, event_o and irq_o to 0.
REQ-026 Reset mid-filter SHALL discard the pending count; no pulse emitted on release unless s[i] later differs from 0 for the full filter time.
REQ-027 An input already high at reset release SHALL produce one pos_edge_o pulse after normal latency.

Configuration
REQ-028 Macro EDGE2EN_MULTI_FILTER_EN defined: glitch filter per REQ-016/017 built in.
REQ-029 Macro undefined: no counters; level_o <= s every cycle; FILTER_LEN ignored; latency per REQ-019.

Verification (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=4, 5 ns clock, macro defined unless stated)
REQ-030 Reset, data_i[0] 0->1 held 10 cycles -> level_o[0]=1 at 6th edge; pos_edge_o[0], any_edge_o[0] high exactly that one cycle; other channels 0.
REQ-031 data_i[1] high 2 cycles then low -> level_o[1], edge outputs, event_o[1] remain 0 throughout.
REQ-032 mode ch2=10, data_i[2] high 8 cycles then low -> pos pulse leaves event_o[2]=0; after neg pulse event_o[2]=1, irq_o=1; clr_i[2] one cycle -> event_o[2]=0, irq_o=0 next edge.
REQ-033 mode ch3=11, clr_i[3] asserted in cycle after an edge pulse on ch3 -> event_o[3] stays 1.
REQ-034 data_i[0] high, rst_n_i pulsed low when counter=2 -> all outputs 0 at once; data_i low on release -> no pulse for 20 cycles.
REQ-035 Macro undefined: data_i[0] 0->1 -> pos pulse at 3rd edge; 1-cycle high on data_i[1] -> pos then neg pulse on consecutive cycles.
